m_trap_controller: RTL and testbench

- M-mode trap sequencer. Sits between the commit stage and the CSR file.
- Accepts synchronous exceptions, pending interrupts and MRET. Prioritises them, then issues the required CSR writes one per cycle over a granted write port: mepc, mcause, mtval, mstatus.
- Tracks the current privilege level and issues a one-cycle pipeline redirect/flush to the trap vector or to mepc.
- All traps go to M-mode; medeleg/mideleg are ignored.

---
 rtl/m_trap_controller_if.sv | 48 ++++
 rtl/m_trap_controller.sv | 190 +++++++++++++++++++
 tb/tb_m_trap_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/m_trap_controller_if.sv
// m_trap_controller_if -- signal bundle between the commit stage, the CSR
// file and the M-mode trap sequencer.
//   Commit side : exception_*, mret_valid_i and irq_boundary_i (requests),
//                 busy_o (stall), redirect_* (flush and redirect), privilege_o.
//   CSR side    : live mip/mie/mstatus/mtvec/mepc, plus the single write port
//                 csr_we_o/csr_addr_o/csr_wdata_o with its grant csr_gnt_i.
// The slave modport is the sequencer's view. The master modport is the
// view of the pipeline and CSR file, which drive the requests.
interface m_trap_controller_if #(
    parameter int MXLEN   = 64,
    parameter int CAUSE_W = 6
);
    logic               exception_valid_i;
    logic [CAUSE_W-1:0] exception_cause_i;
    logic [MXLEN-1:0]   exception_pc_i;
    logic [MXLEN-1:0]   exception_tval_i;
    logic               mret_valid_i;
    logic               irq_boundary_i;
    logic [MXLEN-1:0]   mip_i;
    logic [MXLEN-1:0]   mie_i;
    logic [MXLEN-1:0]   mstatus_i;
    logic [MXLEN-1:0]   mtvec_i;
    logic [MXLEN-1:0]   mepc_i;
    logic               csr_we_o;
    logic [11:0]        csr_addr_o;
    logic [MXLEN-1:0]   csr_wdata_o;
    logic               csr_gnt_i;
    logic               busy_o;
    logic               redirect_valid_o;
    logic [MXLEN-1:0]   redirect_pc_o;
    logic [1:0]         privilege_o;

    modport slave (
        input  exception_valid_i, exception_cause_i, exception_pc_i, exception_tval_i,
        input  mret_valid_i, irq_boundary_i, mip_i, mie_i, mstatus_i, mtvec_i, mepc_i,
        input  csr_gnt_i,
        output csr_we_o, csr_addr_o, csr_wdata_o, busy_o,
        output redirect_valid_o, redirect_pc_o, privilege_o
    );

    modport master (
        output exception_valid_i, exception_cause_i, exception_pc_i, exception_tval_i,
        output mret_valid_i, irq_boundary_i, mip_i, mie_i, mstatus_i, mtvec_i, mepc_i,
        output csr_gnt_i,
        input  csr_we_o, csr_addr_o, csr_wdata_o, busy_o,
        input  redirect_valid_o, redirect_pc_o, privilege_o
    );
endinterface

// File: rtl/m_trap_controller.sv
// m_trap_controller -- M-mode trap sequencer placed between commit and the CSR file.
// The block arbitrates exceptions, MRET and interrupts. It then issues the
// CSR writes for the chosen event one per cycle on a granted port. It ends
// each sequence with a one-cycle redirect and it tracks the privilege level.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus    : m_trap_controller_if.slave, which carries the requests, the live
//            CSRs, the CSR write port, busy/redirect and privilege
module m_trap_controller #(
    parameter int MXLEN   = 64,
    parameter int CAUSE_W = 6
) (
    input  logic                clk_i,
    input  logic                rst_i,
    m_trap_controller_if.slave  bus
);
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;
    localparam logic [1:0]  PRV_M     = 2'b11;

    typedef enum logic [2:0] {
        IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, M_MSTATUS, REDIRECT
    } state_t;

    // Trap context captured when a request is accepted in IDLE
    typedef struct packed {
        logic [MXLEN-1:0] pc;
        logic [MXLEN-1:0] tval;
        logic [MXLEN-1:0] cause;
        logic             irq;
    } trap_ctx_t;

    state_t           state, state_nxt;
    trap_ctx_t        ctx;
    logic [1:0]       priv;
    logic [MXLEN-1:0] tgt;

    // ---------------- interrupt selection ----------------
    logic [MXLEN-1:0] pend;
    logic             irq_hit;
    logic [3:0]       irq_code;
    logic             irq_take;

    assign pend = bus.mip_i & bus.mie_i;

    // Fixed priority is 11 > 3 > 7 > 9 > 1 > 5 > 13
    always_comb begin
        irq_hit  = 1'b1;
        irq_code = 4'd0;
        if      (pend[11]) irq_code = 4'd11;
        else if (pend[3])  irq_code = 4'd3;
        else if (pend[7])  irq_code = 4'd7;
        else if (pend[9])  irq_code = 4'd9;
        else if (pend[1])  irq_code = 4'd1;
        else if (pend[5])  irq_code = 4'd5;
        else if (pend[13]) irq_code = 4'd13;
        else               irq_hit  = 1'b0;
    end

    // Below M, interrupts are always enabled. In M, the MIE bit gates them.
    assign irq_take = irq_hit && bus.irq_boundary_i &&
                      ((priv != PRV_M) || bus.mstatus_i[3]);

    logic [MXLEN-1:0] irq_cause;
    always_comb begin
        irq_cause            = '0;
        irq_cause[MXLEN-1]   = 1'b1;
        irq_cause[3:0]       = irq_code;
    end

    // ---------------- CSR write data ----------------
    logic [MXLEN-1:0] trap_mstatus, mret_mstatus, trap_tgt, base;
    logic [1:0]       mret_priv;

    always_comb begin
        trap_mstatus        = bus.mstatus_i;
        trap_mstatus[7]     = bus.mstatus_i[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = priv;

        mret_mstatus        = bus.mstatus_i;
        mret_mstatus[3]     = bus.mstatus_i[7];
        mret_mstatus[7]     = 1'b1;
        mret_mstatus[12:11] = 2'b00;

        // MPP = 10 is reserved and is treated as U
        mret_priv = (bus.mstatus_i[12:11] == 2'b10) ? 2'b00 : bus.mstatus_i[12:11];

        base = {bus.mtvec_i[MXLEN-1:2], 2'b00};
        if (bus.mtvec_i[1:0] == 2'b01 && ctx.irq)
            trap_tgt = base + (MXLEN'(ctx.cause[CAUSE_W-1:0]) << 2);
        else
            trap_tgt = base;
    end

    // ---------------- state and context ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            ctx   <= '0;
            priv  <= PRV_M;
            tgt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.exception_valid_i) begin
                        ctx.pc    <= bus.exception_pc_i;
                        ctx.tval  <= bus.exception_tval_i;
                        ctx.cause <= MXLEN'(bus.exception_cause_i);
                        ctx.irq   <= 1'b0;
                    end else if (!bus.mret_valid_i && irq_take) begin
                        ctx.pc    <= bus.exception_pc_i;
                        ctx.tval  <= '0;
                        ctx.cause <= irq_cause;
                        ctx.irq   <= 1'b1;
                    end
                end
                W_MSTATUS: if (bus.csr_gnt_i) begin
                    priv <= PRV_M;
                    tgt  <= trap_tgt;
                end
                M_MSTATUS: if (bus.csr_gnt_i) begin
                    priv <= mret_priv;
                    tgt  <= bus.mepc_i;
                end
                default: ;
            endcase
        end
    end

    assign bus.privilege_o = priv;

    // ---------------- next state and outputs ----------------
    always_comb begin
        state_nxt            = state;
        bus.csr_we_o         = 1'b0;
        bus.csr_addr_o       = '0;
        bus.csr_wdata_o      = '0;
        bus.busy_o           = (state != IDLE);
        bus.redirect_valid_o = 1'b0;
        bus.redirect_pc_o    = '0;
        case (state)
            IDLE: begin
                if (bus.exception_valid_i)  state_nxt = W_MEPC;
                else if (bus.mret_valid_i)  state_nxt = M_MSTATUS;
                else if (irq_take)          state_nxt = W_MEPC;
            end
            W_MEPC: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_addr_o  = A_MEPC;
                bus.csr_wdata_o = {ctx.pc[MXLEN-1:2], 2'b00};
                if (bus.csr_gnt_i) state_nxt = W_MCAUSE;
            end
            W_MCAUSE: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_addr_o  = A_MCAUSE;
                bus.csr_wdata_o = ctx.cause;
                if (bus.csr_gnt_i) state_nxt = W_MTVAL;
            end
            W_MTVAL: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_addr_o  = A_MTVAL;
                bus.csr_wdata_o = ctx.tval;
                if (bus.csr_gnt_i) state_nxt = W_MSTATUS;
            end
            W_MSTATUS: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_addr_o  = A_MSTATUS;
                bus.csr_wdata_o = trap_mstatus;
                if (bus.csr_gnt_i) state_nxt = REDIRECT;
            end
            M_MSTATUS: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_addr_o  = A_MSTATUS;
                bus.csr_wdata_o = mret_mstatus;
                if (bus.csr_gnt_i) state_nxt = REDIRECT;
            end
            REDIRECT: begin
                bus.redirect_valid_o = 1'b1;
                bus.redirect_pc_o    = tgt;
                state_nxt            = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_m_trap_controller.sv
// tb_m_trap_controller -- directed-vector bench for m_trap_controller.
module tb_m_trap_controller;
    localparam int MXLEN   = 64;
    localparam int CAUSE_W = 6;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    m_trap_controller_if #(.MXLEN(MXLEN), .CAUSE_W(CAUSE_W)) bus ();

    m_trap_controller #(.MXLEN(MXLEN), .CAUSE_W(CAUSE_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [11:0] addr, input logic [63:0] data);
        chk({tag, "_we"},   64'(bus.csr_we_o), 64'd1);
        chk({tag, "_addr"}, 64'(bus.csr_addr_o), 64'(addr));
        chk({tag, "_data"}, bus.csr_wdata_o, data);
        chk({tag, "_busy"}, 64'(bus.busy_o), 64'd1);
    endtask

    task automatic chk_redir(input string tag, input logic [63:0] pc);
        chk({tag, "_rv"}, 64'(bus.redirect_valid_o), 64'd1);
        chk({tag, "_rpc"}, bus.redirect_pc_o, pc);
        chk({tag, "_we"}, 64'(bus.csr_we_o), 64'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
        chk({tag, "_rv"}, 64'(bus.redirect_valid_o), 64'd0);
        chk({tag, "_rpc"}, bus.redirect_pc_o, 64'd0);
        chk({tag, "_we"}, 64'(bus.csr_we_o), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.exception_valid_i = 1'b0;
        bus.exception_cause_i = '0;
        bus.exception_pc_i    = '0;
        bus.exception_tval_i  = '0;
        bus.mret_valid_i      = 1'b0;
        bus.irq_boundary_i    = 1'b0;
        bus.mip_i             = '0;
        bus.mie_i             = '0;
        bus.mstatus_i         = 64'h8;
        bus.mtvec_i           = 64'h8000_1000;
        bus.mepc_i            = '0;
        bus.csr_gnt_i         = 1'b1;

        // Reset state
        step(); step();
        chk_idle("rst");
        chk("rst_priv", 64'(bus.privilege_o), 64'd3);
        chk("rst_addr", 64'(bus.csr_addr_o), 64'd0);
        chk("rst_wdata", bus.csr_wdata_o, 64'd0);
        rst = 1'b0;
        step();

        // Illegal instruction in M with MIE=1
        bus.exception_valid_i = 1'b1;
        bus.exception_cause_i = 6'd2;
        bus.exception_pc_i    = 64'h8000_0106;
        bus.exception_tval_i  = 64'hDEAD;
        step();
        bus.exception_valid_i = 1'b0;
        chk_wr("ill_mepc", 12'h341, 64'h8000_0104);
        step(); chk_wr("ill_mcause", 12'h342, 64'd2);
        step(); chk_wr("ill_mtval", 12'h343, 64'hDEAD);
        step(); chk_wr("ill_mstatus", 12'h300, 64'h1880);
        step(); chk_redir("ill_redir", 64'h8000_1000);
        chk("ill_priv", 64'(bus.privilege_o), 64'd3);
        step(); chk_idle("ill_done");

        // Vectored interrupt, where MEIP beats MTIP
        bus.mtvec_i        = 64'h8000_1001;
        bus.mip_i          = 64'h880;
        bus.mie_i          = 64'h880;
        bus.irq_boundary_i = 1'b1;
        bus.exception_pc_i = 64'h1000_0000;
        step();
        bus.irq_boundary_i = 1'b0;
        bus.mip_i          = '0;
        chk_wr("irq_mepc", 12'h341, 64'h1000_0000);
        step(); chk_wr("irq_mcause", 12'h342, 64'h8000_0000_0000_000B);
        step(); chk_wr("irq_mtval", 12'h343, 64'd0);
        step(); chk_wr("irq_mstatus", 12'h300, 64'h1880);
        step(); chk_redir("irq_redir", 64'h8000_102C);
        step(); chk_idle("irq_done");

        // MRET to U with MPIE=1 and mepc=0x4000
        bus.mtvec_i      = 64'h8000_1000;
        bus.mstatus_i    = 64'h80;
        bus.mepc_i       = 64'h4000;
        bus.mret_valid_i = 1'b1;
        step();
        bus.mret_valid_i = 1'b0;
        chk_wr("mret_mstatus", 12'h300, 64'h88);
        step(); chk_redir("mret_redir", 64'h4000);
        chk("mret_priv", 64'(bus.privilege_o), 64'd0);
        step(); chk_idle("mret_done");

        // Grant withheld for 3 cycles in W_MCAUSE, taken from U
        bus.mstatus_i         = 64'h0;
        bus.exception_valid_i = 1'b1;
        bus.exception_cause_i = 6'd5;
        bus.exception_pc_i    = 64'h2000;
        bus.exception_tval_i  = 64'h77;
        step();
        bus.exception_valid_i = 1'b0;
        chk_wr("stl_mepc", 12'h341, 64'h2000);
        step();
        bus.csr_gnt_i = 1'b0;
        chk_wr("stl_mcause0", 12'h342, 64'd5);
        step(); chk_wr("stl_mcause1", 12'h342, 64'd5);
        step(); chk_wr("stl_mcause2", 12'h342, 64'd5);
        step(); chk_wr("stl_mcause3", 12'h342, 64'd5);
        bus.csr_gnt_i = 1'b1;
        step(); chk_wr("stl_mtval", 12'h343, 64'h77);
        step(); chk_wr("stl_mstatus", 12'h300, 64'h0);
        chk("stl_priv_pre", 64'(bus.privilege_o), 64'd0);
        step(); chk_redir("stl_redir", 64'h8000_1000);
        chk("stl_priv", 64'(bus.privilege_o), 64'd3);
        step(); chk_idle("stl_done");

        // Exception, MRET and an eligible interrupt in the same cycle
        bus.mstatus_i         = 64'h8;
        bus.mip_i             = 64'h800;
        bus.mie_i             = 64'h800;
        bus.irq_boundary_i    = 1'b1;
        bus.mret_valid_i      = 1'b1;
        bus.exception_valid_i = 1'b1;
        bus.exception_cause_i = 6'd3;
        bus.exception_pc_i    = 64'h3000;
        bus.exception_tval_i  = 64'h0;
        step();
        bus.exception_valid_i = 1'b0;
        bus.mret_valid_i      = 1'b0;
        chk_wr("all_mepc", 12'h341, 64'h3000);
        step(); chk_wr("all_mcause", 12'h342, 64'd3);
        step(); chk_wr("all_mtval", 12'h343, 64'd0);
        step(); chk_wr("all_mstatus", 12'h300, 64'h1880);
        step(); chk_redir("all_redir", 64'h8000_1000);
        bus.mstatus_i = 64'h1880;    // CSR file now holds MIE=0
        step(); chk_idle("all_idle0");
        step(); chk_idle("all_idle1");
        step(); chk_idle("all_idle2");
        bus.mip_i          = '0;
        bus.irq_boundary_i = 1'b0;

        // Drop to U, then reset in the middle of a trap at W_MTVAL
        bus.mstatus_i    = 64'h80;
        bus.mepc_i       = 64'h5000;
        bus.mret_valid_i = 1'b1;
        step();
        bus.mret_valid_i = 1'b0;
        step(); chk_redir("rst2_mret", 64'h5000);
        step(); chk("rst2_priv_u", 64'(bus.privilege_o), 64'd0);
        bus.exception_valid_i = 1'b1;
        bus.exception_cause_i = 6'd1;
        bus.exception_pc_i    = 64'h6000;
        step();
        bus.exception_valid_i = 1'b0;
        step();
        step(); chk_wr("rst2_mtval", 12'h343, 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("rst2_abort");
        chk("rst2_priv", 64'(bus.privilege_o), 64'd3);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst2_no_redir", 64'(bus.redirect_valid_o), 64'd0);
            chk("rst2_no_we", 64'(bus.csr_we_o), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
